// File: rtl/tag_lookup_sequencer.sv
// Sequential tag-lookup controller: scans the ways of one set through a single
// shared comparator, returns hit/miss over a ready/valid handshake, counts results.

module tag_comparator #(
  parameter int tagBits = 12
) (
  input  logic [tagBits-1:0] a,
  input  logic [tagBits-1:0] b,
  output logic               match
);
  assign match = (a == b);
endmodule

module tag_lookup_sequencer #(
  parameter int tagBits = 12,
  parameter int ways    = 8,
  parameter int wayBits = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               reqValid,
  output logic               reqReady,
  input  logic [tagBits-1:0] reqTag,
  output logic [wayBits-1:0] wayIndex,
  input  logic [tagBits-1:0] wayTag,
  input  logic               wayValid,
  output logic               respValid,
  input  logic               respReady,
  output logic               respHit,
  output logic [wayBits-1:0] respWay,
  output logic [31:0]        hitCount,
  output logic [31:0]        missCount
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam logic [wayBits-1:0] LAST_WAY = wayBits'(ways - 1);

  state_t             state, state_nxt;
  logic [tagBits-1:0] tag_q, tag_nxt;
  logic [wayBits-1:0] way_cnt, way_nxt;
  logic               hit_q, hit_nxt;
  logic [wayBits-1:0] rway_q, rway_nxt;
  logic [31:0]        hit_cnt, miss_cnt;
  logic               tag_match, hit_now, last_way, resp_done;

  // One comparator, time-shared across the ways of the set.
  tag_comparator #(.tagBits(tagBits)) u_cmp (
    .a     (tag_q),
    .b     (wayTag),
    .match (tag_match)
  );

  assign hit_now   = (state == SCAN) && tag_match && wayValid;
  assign last_way  = (way_cnt == LAST_WAY);
  assign resp_done = (state == RESP) && respReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tag_q   <= '0;
      way_cnt <= '0;
      hit_q   <= 1'b0;
      rway_q  <= '0;
    end else begin
      state   <= state_nxt;
      tag_q   <= tag_nxt;
      way_cnt <= way_nxt;
      hit_q   <= hit_nxt;
      rway_q  <= rway_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tag_nxt   = tag_q;
    way_nxt   = way_cnt;
    hit_nxt   = hit_q;
    rway_nxt  = rway_q;
    case (state)
      IDLE: begin
        if (reqValid) begin
          tag_nxt   = reqTag;
          way_nxt   = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        // First valid match wins, so lower-numbered duplicates take priority.
        if (hit_now) begin
          hit_nxt   = 1'b1;
          rway_nxt  = way_cnt;
          state_nxt = RESP;
        end else if (last_way) begin
          hit_nxt   = 1'b0;
          rway_nxt  = '0;
          state_nxt = RESP;
        end else begin
          way_nxt = way_cnt + 1'b1;
        end
      end
      RESP: begin
        if (respReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Statistics advance only on a completed response handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (resp_done) begin
      if (hit_q) hit_cnt  <= hit_cnt + 32'd1;
      else       miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign reqReady  = (state == IDLE);
  assign respValid = (state == RESP);
  assign wayIndex  = (state == SCAN) ? way_cnt : '0;
  assign respHit   = hit_q;
  assign respWay   = rway_q;
  assign hitCount  = hit_cnt;
  assign missCount = miss_cnt;

endmodule

// File: doc/tag_lookup_sequencer.md
# tag_lookup_sequencer

Sequential tag-lookup controller for one set of the set-associative L2 cache model. It accepts one lookup request at a time and steps through the ways of the addressed set. It time-shares a single Comparator instance, comparing one way per clock and stopping at the first valid match, then returns hit/miss and the matching way over a ready/valid response handshake. It also keeps free-running hit and miss counters for simulation statistics.

## Interface
- tagBits, 12, width of the tag field; passed to the internal Comparator
- ways, 8, associativity; must be ≥ 2
- wayBits, 3, width of way index; must equal clog2(ways)
- clock  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- reqValid  input  1  lookup request present
- reqReady  output  1  sequencer can accept a request
- reqTag  input  tagBits  tag to look up; sampled on accept
- wayIndex  output  wayBits  way currently being read from tag store
- wayTag  input  tagBits  stored tag of way wayIndex (combinational read, same cycle)
- wayValid  input  1  valid bit of way wayIndex (same cycle)
- respValid  output  1  lookup result available
- respReady  input  1  consumer accepts result
- respHit  output  1  1 = hit, 0 = miss; meaningful while respValid
- respWay  output  wayBits  matching way on hit; 0 on miss
- hitCount  output  32  completed hits since reset, wraps modulo 2^32
- missCount  output  32  completed misses since reset, wraps modulo 2^32

## Operation
- States: IDLE, SCAN, RESP. Encoding is free.
- IDLE:
  - reqReady=1; wayIndex=0.
  - On reqValid=1 at a rising edge: latch reqTag into the internal tag register, clear way counter to 0, go to SCAN.
- SCAN:
  - reqReady=0; wayIndex=way counter.
  - The Comparator compares latched tag against wayTag. hit_now = match & wayValid.
  - If hit_now: latch respHit=1 and respWay=wayIndex; go to RESP.
  - Else if wayIndex==ways-1: latch respHit=0 and respWay=0; go to RESP.
  - Else increment the way counter and stay in SCAN.
  - A matching tag with wayValid=0 is not a hit; scanning continues.
  - If several ways match, the lowest-numbered valid way wins.
- RESP:
  - respValid=1. respHit and respWay are held stable until the handshake.
  - On respReady=1 at an edge: increment hitCount or missCount, then go to IDLE.
  - respValid stays high with stable data while respReady=0; there is no timeout.
- Requests arriving outside IDLE are not accepted, because reqReady=0. The requester holds reqValid.
- The way counter never exceeds ways-1. There is no wrap inside a lookup.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, reqReady=1, respValid=0, respHit=0, respWay=0, wayIndex=0, hitCount=0, missCount=0.
- Reset asserted mid-SCAN or mid-RESP aborts the lookup. No counter is incremented and no response is emitted.
- Accept edge E0 is reqValid & reqReady. Way k is presented during the cycle after edge E(k).
- Hit in way k: respValid rises after edge E(k+1).
  - Best case, way 0: 1 cycle after accept.
- Miss: respValid rises after edge E(ways), i.e. ways cycles after accept.
- Response handshake edge: respValid & respReady. reqReady is 1 from the next cycle onward.
  - Minimum back-to-back lookup interval: latency + 2 cycles.
- respReady already high on entry to RESP: respValid is high for exactly one cycle.
- Counters update on the response handshake edge only. Both are visible the cycle after.
- All outputs are registered or decoded from state/registers only. There are no combinational paths from req or resp inputs to outputs.

## Test plan
- Reset: assert reset mid-SCAN with reqTag=0x0AB.
  - Outputs immediately go to reset values; counters stay 0.
- Hit way 0: store tag 0x123 valid in way 0, reqTag=0x123, respReady=1.
  - respValid high 1 cycle after accept, respHit=1, respWay=0, hitCount=1.
- Hit way 5 with invalid match: 0x3C0 in way 2 (invalid) and way 5 (valid).
  - respHit=1, respWay=5, respValid 6 cycles after accept.
- Miss: no way holds 0xFFF; ways=8.
  - respHit=0, respWay=0, respValid 8 cycles after accept, missCount=1.
- Backpressure: hit in way 1, hold respReady=0 for 4 cycles.
  - respValid, respHit=1, respWay=1 stable for those 4 cycles.
  - reqReady=0 throughout, with a second reqValid pending.
  - Second request accepted only after the handshake.
- Duplicate tags: 0x055 valid in ways 3 and 6.
  - respWay=3.
  - Then 2^32 wrap check: force hitCount=0xFFFFFFFF, complete one hit, and hitCount reads 0.
